// File: rtl/spike_synapse.sv
// Current-mode synapse: each spike edge adds a weight to a saturating current that then decays
// geometrically on a prescaled tick. Define SPIKE_SYNC_EN to add a two-flop input synchroniser.
module spike_synapse #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DECAY_PERIOD = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_in,
    input  logic [WIDTH-1:0] weight,
    input  logic [2:0]       decay_shift,
    output logic [WIDTH-1:0] i_syn,
    output logic             active,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int unsigned      PW       = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DECAY_PERIOD - 1);
    localparam logic [WIDTH-1:0] I_MAX    = '1;
    localparam logic [WIDTH-1:0] I_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {StIdle, StDecay} state_t;

    state_t           state_q;
    logic [PW-1:0]    pre_q;
    logic             spike_q;
    logic             spike_s;
    logic             spike_event;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat_sum;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] decayed;

`ifdef SPIKE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], spike_in};
        end
    end

    assign spike_s = sync_q[1];
`else
    assign spike_s = spike_in;
`endif

    always_comb begin
        spike_event = spike_s & ~spike_q;
        sum         = {1'b0, i_syn} + {1'b0, weight};
        sat_sum     = sum[WIDTH] ? I_MAX : sum[WIDTH-1:0];
        shifted     = i_syn >> decay_shift;
        // A shift that truncates to zero still has to make progress towards zero.
        dec         = (shifted == '0) ? I_ONE : shifted;
        decayed     = (dec >= i_syn) ? '0 : i_syn - dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            spike_q   <= 1'b0;
            i_syn     <= '0;
            active    <= 1'b0;
            event_cnt <= '0;
        end else begin
            spike_q <= spike_s;
            if (spike_event && event_cnt != CNT_MAX) begin
                event_cnt <= event_cnt + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    pre_q <= '0;
                    if (spike_event && weight != '0) begin
                        i_syn   <= sat_sum;
                        active  <= 1'b1;
                        state_q <= StDecay;
                    end
                end
                StDecay: begin
                    // An event pre-empts a coincident decay tick and restarts the period.
                    if (spike_event) begin
                        i_syn <= sat_sum;
                        pre_q <= '0;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        i_syn <= decayed;
                        if (decayed == '0) begin
                            active  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed scenarios plus randomized spike trains, all
// compared against a cycle-level arithmetic model of the synapse.
module tb_spike_synapse;

    localparam int WIDTH        = 8;
    localparam int DECAY_PERIOD = 16;
    localparam int CNT_W        = 8;
`ifdef SPIKE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             spike_in    = 1'b0;
    logic [WIDTH-1:0] weight      = '0;
    logic [2:0]       decay_shift = '0;
    logic [WIDTH-1:0] i_syn;
    logic             active;
    logic [CNT_W-1:0] event_cnt;

    always #5 clk = ~clk;

    spike_synapse #(
        .WIDTH        (WIDTH),
        .DECAY_PERIOD (DECAY_PERIOD),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spike_in    (spike_in),
        .weight      (weight),
        .decay_shift (decay_shift),
        .i_syn       (i_syn),
        .active      (active),
        .event_cnt   (event_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: current, event count, cycles since last add/tick, last seen spike level.
    int m_cur;
    int m_cnt;
    int m_phase;
    int m_prev;
    int hist[3];

    int train[14] = '{30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur   = 0;
        m_cnt   = 0;
        m_phase = 0;
        m_prev  = 0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    task automatic model_step(input logic s);
        int seen;
        int d;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int'(s);
        seen    = hist[LAT];
        if (seen != 0 && m_prev == 0) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cur > 0 || weight != 0) begin
                m_cur = m_cur + int'(weight);
                if (m_cur > (1 << WIDTH) - 1) m_cur = (1 << WIDTH) - 1;
                m_phase = 0;
            end
        end else if (m_cur > 0) begin
            m_phase++;
            if (m_phase == DECAY_PERIOD) begin
                m_phase = 0;
                d = m_cur >> decay_shift;
                if (d == 0) d = 1;
                m_cur = (d > m_cur) ? 0 : m_cur - d;
            end
        end
        m_prev = seen;
    endtask

    // Drive one clock cycle of stimulus and compare all outputs just after the edge.
    task automatic step(input logic s);
        spike_in = s;
        model_step(s);
        @(posedge clk);
        #1;
        check_eq("i_syn", int'(i_syn), m_cur);
        check_eq("active", int'(active), int'(m_cur > 0));
        check_eq("event_cnt", int'(event_cnt), m_cnt);
    endtask

    // Assert reset between edges, confirm it acts immediately, release between edges.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        check_eq("rst_i_syn", int'(i_syn), 0);
        check_eq("rst_active", int'(active), 0);
        check_eq("rst_event_cnt", int'(event_cnt), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic lvl;
        model_reset();

        // Single decay train.
        weight      = 40;
        decay_shift = 2;
        do_reset();
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("train_add", int'(i_syn), 40);
        check_eq("train_active", int'(active), 1);
        foreach (train[k]) begin
            repeat (DECAY_PERIOD) step(1'b0);
            check_eq("train_decay", int'(i_syn), train[k]);
        end
        check_eq("train_idle", int'(active), 0);
        check_eq("train_cnt", int'(event_cnt), 1);

        // Saturation.
        do_reset();
        weight = 200;
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("sat_first", int'(i_syn), 200);
        repeat (4 - LAT) step(1'b0);
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("sat_second", int'(i_syn), 255);
        check_eq("sat_cnt", int'(event_cnt), 2);
        repeat (DECAY_PERIOD) step(1'b0);
        check_eq("sat_tick", int'(i_syn), 192);

        // Level hold gives one event; a new rising edge gives another.
        do_reset();
        weight = 10;
        repeat (10) step(1'b1);
        check_eq("hold_i_syn", int'(i_syn), 10);
        check_eq("hold_cnt", int'(event_cnt), 1);
        step(1'b0);
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("hold_second_i_syn", int'(i_syn), 20);
        check_eq("hold_second_cnt", int'(event_cnt), 2);

        // Event landing on the decay tick wins and restarts the period.
        do_reset();
        weight = 40;
        step(1'b1);
        repeat (DECAY_PERIOD - 1) step(1'b0);
        weight = 5;
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("coinc_add", int'(i_syn), 45);
        repeat (DECAY_PERIOD - 1) step(1'b0);
        check_eq("coinc_hold", int'(i_syn), 45);
        step(1'b0);
        check_eq("coinc_tick", int'(i_syn), 34);

        // Reset mid-decay, then no spurious event with spike_in low.
        do_reset();
        weight = 50;
        step(1'b1);
        repeat (LAT + 5) step(1'b0);
        check_eq("middecay_i_syn", int'(i_syn), 50);
        do_reset();
        repeat (20) step(1'b0);
        check_eq("post_rst_cnt", int'(event_cnt), 0);
        check_eq("post_rst_i_syn", int'(i_syn), 0);

        // Shift of zero empties the current on the first tick.
        decay_shift = 0;
        step(1'b1);
        repeat (LAT) step(1'b0);
        check_eq("shift0_add", int'(i_syn), 50);
        repeat (DECAY_PERIOD - 1) step(1'b0);
        check_eq("shift0_hold", int'(i_syn), 50);
        step(1'b0);
        check_eq("shift0_zero", int'(i_syn), 0);
        check_eq("shift0_active", int'(active), 0);

        // Event counter saturation.
        do_reset();
        decay_shift = 3;
        repeat (300) begin
            weight = WIDTH'($urandom_range(0, 255));
            step(1'b1);
            step(1'b0);
        end
        check_eq("cnt_sat", int'(event_cnt), 255);

        // Randomized spike trains with occasional asynchronous resets.
        do_reset();
        lvl = 1'b0;
        repeat (4000) begin
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            if ($urandom_range(0, 3) == 0) weight = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) decay_shift = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            step(lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
Current-mode synapse that sits downstream of a spiking neuron and drives the i_ext input of the next neuron.
- Converts a spike train back into a decaying synaptic current.
- Each detected spike adds a weight to the current, with saturation.
- Between spikes the current decays geometrically on a prescaled tick until it reaches zero.

Parameters:
WIDTH, 8, bit width of weight and i_syn
DECAY_PERIOD, 16, clk cycles between decay steps (>=2)
CNT_W, 8, width of saturating event counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
spike_in  input  1  spike level from upstream neuron
weight  input  WIDTH  unsigned increment applied per spike event
decay_shift  input  3  decay step = i_syn >> decay_shift
i_syn  output  WIDTH  synaptic current, unsigned, registered
active  output  1  high while i_syn nonzero (state DECAY), registered
event_cnt  output  CNT_W  count of accepted spike events, saturating

Behaviour:
- Reset (async, active-high): i_syn=0, active=0, event_cnt=0, prescaler=0, spike_d=0, state=IDLE. Takes effect immediately, including mid-decay.
- Edge detect:
  - spike_d registers the spike level.
  - event = spike_s & ~spike_d, where spike_s = spike_in, or the synchronised copy (see Optional Feature).
  - A level held high for N cycles gives exactly one event.
  - spike_d resets to 0, so spike_in high across reset release yields one event at the first edge.
- Latency: i_syn and event_cnt update on the same rising edge at which the event is sampled.
- Add: sum = i_syn + weight computed in WIDTH+1 bits; i_syn <= (sum > 2^WIDTH-1) ? 2^WIDTH-1 : sum.
- State IDLE (i_syn==0):
  - Prescaler held at 0.
  - On event with weight!=0: apply add, go to DECAY.
  - On event with weight==0: stay IDLE, event still counted.
- State DECAY:
  - Prescaler increments each cycle.
  - Decay tick when prescaler==DECAY_PERIOD-1: prescaler <= 0; dec = i_syn >> decay_shift; if dec==0 then dec=1; i_syn <= i_syn - dec (never below 0).
  - Go to IDLE when the result is 0.
- Event in DECAY: apply add, prescaler <= 0, stay DECAY.
- Event coincident with a decay tick: the event wins, the decay step is skipped, prescaler <= 0.
- decay_shift==0: dec = i_syn, so the current reaches 0 on the first tick.
- weight and decay_shift are sampled only on the cycle they are used; changes mid-decay take effect at the next add or tick.
- active: registered, equals (next state == DECAY); high on the same edge i_syn becomes nonzero, low on the same edge i_syn reaches 0.
- event_cnt: +1 per event, saturates at 2^CNT_W-1, cleared only by reset.

Optional Feature:
SPIKE_SYNC_EN
- Defined: spike_in passes through a two-flop synchroniser (both flops reset to 0) before edge detection. Event latency grows by 2 clk cycles. Use this when spike_in comes from an unrelated clock or a pin.
- Undefined: spike_in is used directly and must be synchronous to clk. Latency is 0 extra cycles.

Test Plan:
- Single decay train (WIDTH=8, DECAY_PERIOD=16, weight=40, decay_shift=2): reset, then pulse spike_in for 1 cycle.
  - i_syn=40 and active=1 on that edge.
  - Each subsequent 16 cycles: 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0.
  - active drops on the edge i_syn reaches 0; event_cnt=1.
- Saturation: weight=200, two 1-cycle spikes 5 cycles apart.
  - i_syn = 200, then 255.
  - event_cnt=2; the first tick then gives 255-63=192 (shift 2).
- Level hold: spike_in high for 10 cycles, weight=10.
  - Exactly one event: i_syn=10, event_cnt=1.
  - Falling then rising again gives a second event.
- Coincidence: time a spike edge to land on the prescaler==15 cycle with i_syn=40, weight=5.
  - i_syn=45 with no decay on that edge.
  - Next decay exactly 16 cycles later gives 45-11=34.
- Reset mid-operation: assert reset asynchronously between clk edges during decay.
  - i_syn, active and event_cnt read 0 before the next edge.
  - After release with spike_in low, there is no spurious event.
- decay_shift=0 plus counter saturation:
  - weight=50 spike: i_syn becomes 0 after one tick (16 cycles).
  - With CNT_W=2, five spikes leave event_cnt=3.
  - With SPIKE_SYNC_EN defined, i_syn rises 2 cycles later than without it.
